// File: rtl/nmi_hsync_gen_pkg.sv
// Shared ZX81 line-timing constants and a small window helper.
// The ULA and video blocks import the same constants so every block
// agrees on where a scan line starts and where its sync pulse sits.
package nmi_hsync_gen_pkg;

  // CPU cycles per scan line.
  localparam int ZX_LINE_LEN   = 207;
  // First sync cycle; clamped so the pulse ends on the last cycle of the line.
  localparam int ZX_SYNC_START = 191;
  // Sync / NMI pulse width in cycles.
  localparam int ZX_SYNC_LEN   = 16;

  // True when cycle index c lies in [start, start+len-1].
  function automatic logic in_window(input logic [7:0] c, input int start, input int len);
    return (int'(c) >= start) && (int'(c) < start + len);
  endfunction

endpackage

// File: rtl/nmi_hsync_gen_mod_counter.sv
// Generic wrap-at-N counter with enable, synchronous clear and a
// terminal-count flag (high while count == N-1).
module mod_counter #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == W'(N - 1));

  // Clear has priority over counting; counting wraps from N-1 to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/nmi_hsync_gen.sv
// ZX81 line-timing generator: cycle-within-line counter, horizontal sync,
// NMI pulse gated by the NMI-enable flag, and the 3-bit character-row
// line counter. All outputs are registered.
module nmi_hsync_gen
  import nmi_hsync_gen_pkg::*;
#(
  parameter int LINE_LEN   = ZX_LINE_LEN,
  parameter int SYNC_START = ZX_SYNC_START,
  parameter int SYNC_LEN   = ZX_SYNC_LEN
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       nmi_on,
  input  logic       nmi_off,
  input  logic       vsync,
  output logic [7:0] cyc,
  output logic [2:0] line_cnt,
  output logic       hsync_n,
  output logic       nmi_n,
  output logic       nmi_en
);

  // Elaboration-time parameter legality check.
  generate
    if (LINE_LEN < 2 || LINE_LEN > 256) begin : g_bad_line_len
      $fatal(1, "nmi_hsync_gen: LINE_LEN must be in 2..256");
    end
    if (SYNC_START < 0 || SYNC_LEN < 1 || SYNC_START + SYNC_LEN > LINE_LEN) begin : g_bad_sync
      $fatal(1, "nmi_hsync_gen: sync window must fit inside the line");
    end
  endgenerate

  logic       cyc_tc;
  logic [7:0] cyc_nxt;
  logic       in_w_nxt;
  logic       start_nxt;
  logic       arm;
  logic       unused_line_tc;

  mod_counter #(.N(LINE_LEN), .W(8)) u_cyc (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .clr     (1'b0),
    .count   (cyc),
    .tc      (cyc_tc)
  );

  // vsync holds the row counter at 0 and beats the end-of-line increment.
  mod_counter #(.N(8), .W(3)) u_line (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (cyc_tc),
    .clr     (vsync),
    .count   (line_cnt),
    .tc      (unused_line_tc)
  );

  // Value cyc takes after the coming edge; sync outputs are registered
  // from it so they line up with cyc rather than lag it by one cycle.
  assign cyc_nxt   = cyc_tc ? 8'd0 : cyc + 8'd1;
  assign in_w_nxt  = in_window(cyc_nxt, SYNC_START, SYNC_LEN);
  assign start_nxt = (int'(cyc_nxt) == SYNC_START);

  // Enable flag, window arming, and the registered sync/NMI outputs.
  // arm is captured only when the window opens, so enabling mid-window
  // gives no runt pulse and disabling mid-window never truncates one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nmi_en  <= 1'b0;
      arm     <= 1'b0;
      hsync_n <= 1'b1;
      nmi_n   <= 1'b1;
    end else begin
      if (nmi_off) begin
        nmi_en <= 1'b0;
      end else if (nmi_on) begin
        nmi_en <= 1'b1;
      end
      if (start_nxt) begin
        arm <= nmi_en;
      end
      hsync_n <= ~in_w_nxt;
      nmi_n   <= ~(in_w_nxt && (start_nxt ? nmi_en : arm));
    end
  end

endmodule
